// File: rtl/rv_mem_arb.sv
`timescale 1ns/1ps
// rv_mem_arb: shares one memory port between instruction fetch (read-only) and
// the memory-access stage, D-over-I priority bounded by a starvation limit.
module rv_mem_arb #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_flush,
  output logic                i_rsp_valid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t            state_q;
  owner_t            owner_q;
  logic              drop_q;
  logic [CNT_W-1:0]  streak_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [BE_W-1:0]   mem_be_q;

  logic streak_full;
  logic grant_i;
  logic grant_d;
  logic done;
  logic flush_hit;

  always_comb begin
    streak_full = (streak_q == STREAK_MAX);
    grant_i     = i_req && (!d_req || streak_full);
    grant_d     = d_req && !grant_i;
    done        = (state_q == WAIT) && mem_rvalid;
    flush_hit   = i_flush && (owner_q == OWN_I) && (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      drop_q      <= 1'b0;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            state_q     <= REQ;
            owner_q     <= OWN_I;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= i_addr;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            streak_q    <= '0;
          end else if (grant_d) begin
            state_q     <= REQ;
            owner_q     <= OWN_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            mem_be_q    <= d_be;
            // Only D grants that make a waiting fetch wait longer count.
            if (i_req && !streak_full) begin
              streak_q <= streak_q + CNT_W'(1);
            end
          end
        end
        REQ: begin
          if (flush_hit) begin
            drop_q <= 1'b1;
          end
          if (mem_gnt) begin
            state_q   <= WAIT;
            mem_req_q <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
          end else if (flush_hit) begin
            drop_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          drop_q    <= 1'b0;
        end
      endcase
    end
  end

  // A flush arriving in the completion cycle also discards that response.
  always_comb begin
    i_rsp_valid = done && (owner_q == OWN_I) && !drop_q && !i_flush;
    d_rsp_valid = done && (owner_q == OWN_D);
    i_rdata     = i_rsp_valid ? mem_rdata : '0;
    d_rdata     = (d_rsp_valid && !mem_we_q) ? mem_rdata : '0;
    i_stall     = i_req && !i_rsp_valid;
    d_stall     = d_req && !d_rsp_valid;
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_rv_mem_arb.sv
`timescale 1ns/1ps
// tb_rv_mem_arb: directed scenarios for the shared memory-port arbiter, the
// bench plays both requesters and the memory.
module tb_rv_mem_arb;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  logic              clk;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_flush;
  logic              i_rsp_valid;
  logic [DATA_W-1:0] i_rdata;
  logic              i_stall;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  rv_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_rsp_valid(i_rsp_valid), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Serves one transaction as a 1-cycle-gnt, 1-cycle-rvalid memory and
  // reports what the arbiter put on the port and which side got the response.
  task automatic run_txn(input logic [DATA_W-1:0] rd, output logic [ADDR_W-1:0] addr,
                         output logic [BE_W-1:0] be, output logic irsp, output logic drsp,
                         output logic [DATA_W-1:0] rdat, output bit ok);
    int n;
    n = 0; ok = 1'b0; addr = '0; be = '0; irsp = 1'b0; drsp = 1'b0; rdat = '0;
    while (!mem_req && n < 20) begin
      step();
      n++;
    end
    if (!mem_req) return;
    addr = mem_addr;
    be   = mem_be;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd;
    #1;
    irsp = i_rsp_valid;
    drsp = d_rsp_valid;
    rdat = irsp ? i_rdata : d_rdata;
    ok = 1'b1;
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    step();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if ({mem_we, mem_addr, mem_wdata, mem_be} !== '0) begin failures++;
      $display("FAIL reset_mem_fields got we=%b addr=%h wdata=%h be=%h exp=all 0", mem_we, mem_addr, mem_wdata, mem_be); end
    checks++; if ({i_rsp_valid, d_rsp_valid} !== 2'b00) begin failures++;
      $display("FAIL reset_rsp_valid got i=%b d=%b exp=0 0", i_rsp_valid, d_rsp_valid); end
    checks++; if ({i_rdata, d_rdata} !== '0) begin failures++;
      $display("FAIL reset_rdata got i=%h d=%h exp=0 0", i_rdata, d_rdata); end
    rst = 1'b0;
    step();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_idle_no_req got=%b exp=0", mem_req); end
  endtask

  task automatic test_single_load();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF; #1;
    checks++; if ({d_stall, mem_req, i_stall} !== 3'b100) begin failures++;
      $display("FAIL load_c0 got stall=%b req=%b istall=%b exp=1 0 0", d_stall, mem_req, i_stall); end
    step();
    checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin failures++;
      $display("FAIL load_c1_req got req=%b we=%b addr=%h exp=1 0 00000100", mem_req, mem_we, mem_addr); end
    checks++; if ({d_stall, d_rsp_valid} !== 2'b10) begin failures++;
      $display("FAIL load_c1_stall got stall=%b rsp=%b exp=1 0", d_stall, d_rsp_valid); end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    checks++; if ({d_rsp_valid, d_rdata} !== {1'b1, 32'hDEADBEEF}) begin failures++;
      $display("FAIL load_c2_rsp got valid=%b rdata=%h exp=1 deadbeef", d_rsp_valid, d_rdata); end
    checks++; if ({d_stall, mem_req, i_rsp_valid, i_rdata} !== {3'b000, 32'h0}) begin failures++;
      $display("FAIL load_c2_side got stall=%b req=%b irsp=%b irdata=%h exp=0 0 0 0", d_stall, mem_req, i_rsp_valid, i_rdata); end
    step();
    d_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; #1;
    checks++; if ({d_rsp_valid, d_rdata} !== {1'b0, 32'h0}) begin failures++;
      $display("FAIL load_c3_quiet got valid=%b rdata=%h exp=0 0", d_rsp_valid, d_rdata); end
    step();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL load_c4_no_req got=%b exp=0", mem_req); end
  endtask

  task automatic test_store_backpressure();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678; d_be = 4'hF;
    step();
    for (int c = 1; c <= 4; c++) begin
      if (c >= 2) begin
        d_we = 1'b0; d_addr = 32'h999 + 32'(c); d_wdata = 32'hBAD0_0000 + 32'(c); d_be = 4'h3;
      end
      mem_gnt = (c == 4); #1;
      checks++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 1'b1, 32'h40, 32'h12345678, 4'hF}) begin
        failures++;
        $display("FAIL store_hold_c%0d got req=%b we=%b addr=%h wdata=%h be=%h exp=1 1 00000040 12345678 f",
                 c, mem_req, mem_we, mem_addr, mem_wdata, mem_be);
      end
      step();
    end
    mem_gnt = 1'b0; i_flush = 1'b1; #1;
    checks++; if ({mem_req, d_rsp_valid} !== 2'b00) begin failures++;
      $display("FAIL store_wait got req=%b rsp=%b exp=0 0", mem_req, d_rsp_valid); end
    step();
    i_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF; #1;
    checks++; if ({d_rsp_valid, d_rdata, d_stall} !== {1'b1, 32'h0, 1'b0}) begin failures++;
      $display("FAIL store_ack got valid=%b rdata=%h stall=%b exp=1 0 0", d_rsp_valid, d_rdata, d_stall); end
    step();
    d_req = 1'b0; d_we = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step();
  endtask

  task automatic test_contention();
    logic [ADDR_W-1:0] a;
    logic [BE_W-1:0]   be;
    logic              ir, dr, exp_i;
    logic [DATA_W-1:0] rd, tag;
    bit                ok;
    do_reset();
    i_req = 1'b1; i_addr = 32'h1000; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_be = 4'hF;
    for (int k = 0; k < 10; k++) begin
      exp_i = (k == 4) || (k == 9);
      tag = 32'hA0000000 + 32'(k);
      run_txn(tag, a, be, ir, dr, rd, ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL contention_timeout txn=%0d no mem_req", k);
      end else begin
        checks++; if (a !== (exp_i ? 32'h1000 : 32'h2000)) begin failures++;
          $display("FAIL contention_order txn=%0d got addr=%h exp=%h", k, a, exp_i ? 32'h1000 : 32'h2000); end
        checks++; if (be !== (exp_i ? 4'h0 : 4'hF)) begin failures++;
          $display("FAIL contention_be txn=%0d got=%h exp=%h", k, be, exp_i ? 4'h0 : 4'hF); end
        checks++; if ({ir, dr} !== (exp_i ? 2'b10 : 2'b01)) begin failures++;
          $display("FAIL contention_route txn=%0d got i=%b d=%b exp_i=%b", k, ir, dr, exp_i); end
        checks++; if (rd !== tag) begin failures++;
          $display("FAIL contention_rdata txn=%0d got=%h exp=%h", k, rd, tag); end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    step();
    step();
  endtask

  task automatic test_flush();
    logic [ADDR_W-1:0] a;
    logic [BE_W-1:0]   be;
    logic              ir, dr;
    logic [DATA_W-1:0] rd;
    bit                ok;
    i_req = 1'b1; i_addr = 32'h200; d_req = 1'b0;
    step();
    checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h200}) begin failures++;
      $display("FAIL flush_fetch_req got req=%b we=%b addr=%h exp=1 0 00000200", mem_req, mem_we, mem_addr); end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; i_flush = 1'b1; #1;
    checks++; if (i_rsp_valid !== 1'b0) begin failures++; $display("FAIL flush_pulse_rsp got=%b exp=0", i_rsp_valid); end
    step();
    i_flush = 1'b0; i_req = 1'b0;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
    checks++; if ({i_rsp_valid, i_rdata, d_rsp_valid} !== {1'b0, 32'h0, 1'b0}) begin failures++;
      $display("FAIL flush_suppress got irsp=%b irdata=%h drsp=%b exp=0 0 0", i_rsp_valid, i_rdata, d_rsp_valid); end
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hF;
    run_txn(32'h33333333, a, be, ir, dr, rd, ok);
    d_req = 1'b0;
    checks++; if ({ok, a, ir, dr, rd} !== {1'b1, 32'h300, 1'b0, 1'b1, 32'h33333333}) begin failures++;
      $display("FAIL flush_next_load got ok=%b addr=%h i=%b d=%b rdata=%h exp=1 00000300 0 1 33333333", ok, a, ir, dr, rd); end
    i_req = 1'b1; i_addr = 32'h204;
    run_txn(32'h44444444, a, be, ir, dr, rd, ok);
    i_req = 1'b0;
    checks++; if ({ok, a, ir, dr, rd} !== {1'b1, 32'h204, 1'b1, 1'b0, 32'h44444444}) begin failures++;
      $display("FAIL flush_next_fetch got ok=%b addr=%h i=%b d=%b rdata=%h exp=1 00000204 1 0 44444444", ok, a, ir, dr, rd); end
    step();
  endtask

  task automatic test_reset_mid();
    logic [ADDR_W-1:0] a;
    logic [BE_W-1:0]   be;
    logic              ir, dr, exp_i;
    logic [DATA_W-1:0] rd;
    bit                ok;
    do_reset();
    i_req = 1'b1; i_addr = 32'h1000; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_be = 4'hF;
    run_txn(32'h1, a, be, ir, dr, rd, ok);
    run_txn(32'h2, a, be, ir, dr, rd, ok);
    step();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_in_req got=%b exp=1", mem_req); end
    rst = 1'b1;
    step();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55555555; #1;
    checks++; if ({mem_req, mem_addr, i_rsp_valid, d_rsp_valid} !== {1'b0, 32'h0, 2'b00}) begin failures++;
      $display("FAIL rstmid_abort got req=%b addr=%h irsp=%b drsp=%b exp=0 0 0 0", mem_req, mem_addr, i_rsp_valid, d_rsp_valid); end
    mem_rvalid = 1'b0; mem_rdata = '0;
    for (int k = 0; k < 5; k++) begin
      exp_i = (k == 4);
      run_txn(32'h60 + 32'(k), a, be, ir, dr, rd, ok);
      checks++; if ({ok, a} !== {1'b1, (exp_i ? 32'h1000 : 32'h2000)}) begin failures++;
        $display("FAIL rstmid_streak txn=%0d got ok=%b addr=%h exp=1 %h", k, ok, a, exp_i ? 32'h1000 : 32'h2000); end
    end
    i_req = 1'b0; d_req = 1'b0;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_be = 4'hF;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11111111; #1;
    checks++; if ({d_rsp_valid, d_rdata} !== {1'b1, 32'h11111111}) begin failures++;
      $display("FAIL b2b_first_rsp got valid=%b rdata=%h exp=1 11111111", d_rsp_valid, d_rdata); end
    step();
    mem_rvalid = 1'b0; mem_rdata = '0; d_addr = 32'h504; #1;
    checks++; if ({mem_req, d_rsp_valid, d_stall} !== 3'b001) begin failures++;
      $display("FAIL b2b_r1 got req=%b rsp=%b stall=%b exp=0 0 1", mem_req, d_rsp_valid, d_stall); end
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h77777777; #1;
    checks++; if ({mem_req, mem_addr, d_rsp_valid} !== {1'b1, 32'h504, 1'b0}) begin failures++;
      $display("FAIL b2b_r2_req got req=%b addr=%h rsp=%b exp=1 00000504 0", mem_req, mem_addr, d_rsp_valid); end
    step();
    mem_gnt = 1'b1; #1;
    checks++; if ({mem_req, d_rsp_valid} !== 2'b10) begin failures++;
      $display("FAIL b2b_gnt_in_req got req=%b rsp=%b exp=1 0", mem_req, d_rsp_valid); end
    step();
    mem_gnt = 1'b0; mem_rdata = 32'h22222222; #1;
    checks++; if ({d_rsp_valid, d_rdata, mem_req} !== {1'b1, 32'h22222222, 1'b0}) begin failures++;
      $display("FAIL b2b_second_rsp got valid=%b rdata=%h req=%b exp=1 22222222 0", d_rsp_valid, d_rdata, mem_req); end
    step();
    d_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step();
  endtask

  initial begin
    do_reset();
    test_single_load();
    test_store_backpressure();
    test_reset();
    test_contention();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
